// File: rtl/tow_key_conditioner.sv
// tow_key_conditioner: synchronises, debounces and edge-detects one active-low
// player KEY, producing a single-cycle press pulse, a debounced held level and
// a wrapping 8-bit press counter.
// Optional build macro: TOW_AUTO_REPEAT_EN adds auto-repeat pulses while held.
module tow_key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  input  logic       enable,
  input  logic       clr_count,
  output logic       press,
  output logic       held,
  output logic [7:0] press_count
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q, sync_d;
  logic             press_q, press_d;
  logic             held_q, held_d;
  logic [7:0]       count_q, count_d;
  logic             key_s;

  assign key_s = sync_q[1];

`ifdef TOW_AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             rpt_armed_q, rpt_armed_d;
  logic [RPT_W-1:0] rpt_next;
  logic [RPT_W-1:0] rpt_target;
  logic             rpt_hit;
`else
  logic unused_rpt_params;
  assign unused_rpt_params = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  // Next-state, debounce counter, pulse generation and press counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    sync_d  = {sync_q[0], key_n};
`ifdef TOW_AUTO_REPEAT_EN
    rpt_d       = rpt_q;
    rpt_armed_d = rpt_armed_q;
    rpt_next    = rpt_q + RPT_W'(1);
    rpt_target  = rpt_armed_q ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY);
    rpt_hit     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = enable;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (key_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef TOW_AUTO_REPEAT_EN
    // Repeat timer runs only in HELD, so it naturally freezes in RELEASE_WAIT
    if (state_q == HELD) begin
      rpt_hit = (rpt_next == rpt_target);
      if (rpt_hit) begin
        rpt_d       = '0;
        rpt_armed_d = 1'b1;
        press_d     = enable & ~press_q;
      end else begin
        rpt_d = rpt_next;
      end
    end
    if ((state_d == IDLE) || (state_q == PRESS_WAIT && state_d == HELD)) begin
      rpt_d       = '0;
      rpt_armed_d = 1'b0;
    end
`endif

    held_d = (state_d == HELD) || (state_d == RELEASE_WAIT);

    if (clr_count) begin
      count_d = 8'd0;
    end else if (press_q) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sync_q  <= 2'b11;
      press_q <= 1'b0;
      held_q  <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      press_q <= press_d;
      held_q  <= held_d;
      count_q <= count_d;
    end
  end

`ifdef TOW_AUTO_REPEAT_EN
  // Auto-repeat timer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_q       <= '0;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_q       <= rpt_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end
`endif

  assign press       = press_q;
  assign held        = held_q;
  assign press_count = count_q;

endmodule
